// File: rtl/lc3_alu_sequencer.sv
// lc3_alu_sequencer
//   Execute-stage controller for the lab LC-3. Takes one instruction per
//   instrValid/instrReady handshake, decodes ADD/AND/NOT, and walks it through
//   IDLE -> DECODE -> EXECUTE -> WRITEBACK against an internal 8x16 register
//   file, updating the NZP condition codes on retirement.
// Ports
//   clk, reset              : rising-edge clock, synchronous active-high reset
//   instrValid/instr        : instruction offer; instrReady marks acceptance
//   loadEn/loadAddr/loadData: direct register write, only taken in IDLE
//   dbgAddr/dbgData         : combinational register-file read port
//   aluControl              : 00 pass A, 01 ADD, 10 AND, 11 NOT (EXECUTE only)
//   regWe                   : register-file write strobe (WRITEBACK only)
//   nzp                     : condition codes {N,Z,P}
//   done/illegal            : one-cycle retirement pulses
module lc3_alu_sequencer #(
  parameter logic [15:0] REG_RESET = 16'h0000,
  parameter logic [2:0]  CC_RESET  = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instrValid,
  input  logic [15:0] instr,
  output logic        instrReady,
  input  logic        loadEn,
  input  logic [2:0]  loadAddr,
  input  logic [15:0] loadData,
  input  logic [2:0]  dbgAddr,
  output logic [15:0] dbgData,
  output logic [1:0]  aluControl,
  output logic        regWe,
  output logic [2:0]  nzp,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [1:0] {IDLE, DECODE, EXECUTE, WRITEBACK} state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ra_q, ra_d;
  logic [15:0] rb_q, rb_d;
  logic [2:0]  dr_q, dr_d;
  logic [1:0]  op_q, op_d;
  logic        legal_q, legal_d;
  logic [15:0] result_q, result_d;
  logic [2:0]  nzp_q, nzp_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic [15:0] regs_q [8];

  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] opnd_b;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (instrValid) state_d = DECODE;
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = WRITEBACK;
      WRITEBACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output logic; done/illegal are registered so they land in the IDLE cycle
  // that follows WRITEBACK, alongside instrReady.
  always_comb begin
    instrReady = (state_q == IDLE);
    aluControl = (state_q == EXECUTE) ? op_q : 2'b00;
    regWe      = (state_q == WRITEBACK) && legal_q;
    done       = done_q;
    illegal    = illegal_q;
    nzp        = nzp_q;
    dbgData    = regs_q[dbgAddr];
  end

  // Immediate form sign-extends IR[4:0]; otherwise SR2 from the register file.
  assign opnd_b = ir_q[5] ? {{11{ir_q[4]}}, ir_q[4:0]} : rb_q;

  // Datapath next values
  always_comb begin
    ir_d      = ir_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    dr_d      = dr_q;
    op_d      = op_q;
    legal_d   = legal_q;
    result_d  = result_q;
    nzp_d     = nzp_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (instrValid) ir_d = instr;
      end
      DECODE: begin
        ra_d = regs_q[ir_q[8:6]];
        rb_d = regs_q[ir_q[2:0]];
        dr_d = ir_q[11:9];
        case (ir_q[15:12])
          4'b0001: begin op_d = 2'b01; legal_d = 1'b1; end
          4'b0101: begin op_d = 2'b10; legal_d = 1'b1; end
          4'b1001: begin op_d = 2'b11; legal_d = 1'b1; end
          default: begin op_d = 2'b00; legal_d = 1'b0; end
        endcase
      end
      EXECUTE: begin
        case (op_q)
          2'b01:   result_d = ra_q + opnd_b;
          2'b10:   result_d = ra_q & opnd_b;
          2'b11:   result_d = ~ra_q;
          default: result_d = ra_q;
        endcase
      end
      WRITEBACK: begin
        done_d    = 1'b1;
        illegal_d = ~legal_q;
        if (legal_q) begin
          if (result_q[15])          nzp_d = 3'b100;
          else if (result_q == '0)   nzp_d = 3'b010;
          else                       nzp_d = 3'b001;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q      <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      dr_q      <= '0;
      op_q      <= '0;
      legal_q   <= 1'b0;
      result_q  <= '0;
      nzp_q     <= CC_RESET;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      ir_q      <= ir_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      dr_q      <= dr_d;
      op_q      <= op_d;
      legal_q   <= legal_d;
      result_q  <= result_d;
      nzp_q     <= nzp_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  // Single register-file write port: boot loads in IDLE, results in WRITEBACK.
  // The two sources live in different states, so they never collide.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = loadAddr;
    wr_data = loadData;
    if (state_q == IDLE && loadEn) begin
      wr_en = 1'b1;
    end else if (state_q == WRITEBACK && legal_q) begin
      wr_en   = 1'b1;
      wr_addr = dr_q;
      wr_data = result_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_reg
      localparam logic [2:0] IDX = 3'(gi);
      always_ff @(posedge clk) begin
        if (reset)                        regs_q[gi] <= REG_RESET;
        else if (wr_en && wr_addr == IDX) regs_q[gi] <= wr_data;
      end
    end
  endgenerate

endmodule

// File: tb/tb_lc3_alu_sequencer.sv
// Scoreboard bench for lc3_alu_sequencer: the stimulus process pushes the
// hand-computed retirement result of each instruction; the monitor pops and
// compares on every done pulse and also checks aluControl/regWe timing.
module tb_lc3_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        instrValid;
  logic [15:0] instr;
  logic        instrReady;
  logic        loadEn;
  logic [2:0]  loadAddr;
  logic [15:0] loadData;
  logic [2:0]  dbgAddr;
  logic [15:0] dbgData;
  logic [1:0]  aluControl;
  logic        regWe;
  logic [2:0]  nzp;
  logic        done;
  logic        illegal;

  logic        dbg_sel = 1'b0;
  logic [2:0]  mon_addr = 3'd0;
  logic [2:0]  stim_addr = 3'd0;
  assign dbgAddr = dbg_sel ? mon_addr : stim_addr;

  lc3_alu_sequencer dut (
    .clk(clk), .reset(reset),
    .instrValid(instrValid), .instr(instr), .instrReady(instrReady),
    .loadEn(loadEn), .loadAddr(loadAddr), .loadData(loadData),
    .dbgAddr(dbgAddr), .dbgData(dbgData),
    .aluControl(aluControl), .regWe(regWe), .nzp(nzp),
    .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  aluc;
    logic        we;
    logic        ill;
    logic [2:0]  nzp;
    logic [2:0]  addr;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic push(input logic [1:0] aluc, input logic we, input logic ill,
                      input logic [2:0] cc, input logic [2:0] addr, input logic [15:0] val);
    exp_t e;
    e.aluc = aluc; e.we = we; e.ill = ill; e.nzp = cc; e.addr = addr; e.val = val;
    exp_q.push_back(e);
  endtask

  // Offer one instruction (optionally with a same-cycle load); returns in DECODE.
  task automatic issue(input logic [15:0] w, input logic ld, input logic [2:0] la,
                       input logic [15:0] lv);
    logic acc;
    acc = 1'b0;
    instr = w; instrValid = 1'b1;
    loadEn = ld; loadAddr = la; loadData = lv;
    for (int n = 0; n < 20; n++) begin
      acc = instrReady;
      @(posedge clk); #1;
      loadEn = 1'b0;
      if (acc) break;
    end
    instrValid = 1'b0;
    check("accept", {15'd0, acc}, 16'd1);
  endtask

  task automatic retire_wait();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    loadEn = 1'b1; loadAddr = a; loadData = d;
    @(posedge clk); #1;
    loadEn = 1'b0;
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    bit   inflight;
    int   phase;
    exp_t e;
    logic [1:0] exp_alu;
    logic       exp_we;
    inflight = 1'b0;
    phase = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        inflight = 1'b0;
        phase = 0;
      end else begin
        if (inflight) phase++;
        if (!(inflight && exp_q.size() == 0)) begin
          exp_alu = 2'b00;
          exp_we  = 1'b0;
          if (inflight && phase == 2) exp_alu = exp_q[0].aluc;
          if (inflight && phase == 3) exp_we  = exp_q[0].we;
          check("aluControl", {14'd0, aluControl}, {14'd0, exp_alu});
          check("regWe", {15'd0, regWe}, {15'd0, exp_we});
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", {15'd0, done}, 16'd0);
          end else begin
            e = exp_q.pop_front();
            check("latency", 16'(phase), 16'd4);
            check("illegal", {15'd0, illegal}, {15'd0, e.ill});
            check("nzp", {13'd0, nzp}, {13'd0, e.nzp});
            mon_addr = e.addr;
            dbg_sel = 1'b1;
            #1;
            check("reg", dbgData, e.val);
            dbg_sel = 1'b0;
          end
          inflight = 1'b0;
        end else begin
          check("illegal_idle", {15'd0, illegal}, 16'd0);
        end
        if (inflight && phase > 6) begin
          check("done_timeout", 16'd0, 16'd1);
          inflight = 1'b0;
        end
        if (instrValid && instrReady) begin
          inflight = 1'b1;
          phase = 0;
        end
      end
    end
  end

  initial begin : stimulus
    int acc_cyc[3];
    int count;
    logic acc;
    reset = 1'b1; instrValid = 1'b0; instr = '0;
    loadEn = 1'b0; loadAddr = '0; loadData = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    for (int i = 0; i < 8; i++) begin
      stim_addr = 3'(i);
      #1;
      check("reset_reg", dbgData, 16'h0000);
    end
    check("reset_nzp", {13'd0, nzp}, 16'h0002);
    check("reset_ready", {15'd0, instrReady}, 16'd1);
    check("reset_done", {15'd0, done}, 16'd0);
    @(posedge clk); #1;

    // Reset during EXECUTE of ADD R1,R1,#1 aborts it
    issue(16'h1261, 1'b0, 3'd0, 16'h0);
    @(posedge clk); #1;             // now in EXECUTE
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    stim_addr = 3'd1;
    #1;
    check("abort_r1", dbgData, 16'h0000);
    check("abort_nzp", {13'd0, nzp}, 16'h0002);
    repeat (6) begin @(posedge clk); #1; end

    // ADD R1,R2,R3 with R2=5, R3=3
    load(3'd2, 16'h0005);
    load(3'd3, 16'h0003);
    push(2'b01, 1'b1, 1'b0, 3'b001, 3'd1, 16'h0008);
    issue(16'h1283, 1'b0, 3'd0, 16'h0);
    retire_wait();

    // ADD R4,R2,#-4 with R2=3 ; AND R5,R4,#0
    load(3'd2, 16'h0003);
    push(2'b01, 1'b1, 1'b0, 3'b100, 3'd4, 16'hFFFF);
    issue(16'h18BC, 1'b0, 3'd0, 16'h0);
    retire_wait();
    push(2'b10, 1'b1, 1'b0, 3'b010, 3'd5, 16'h0000);
    issue(16'h5B20, 1'b0, 3'd0, 16'h0);
    retire_wait();

    // NOT R6,R4 with R4=00FF ; ADD R2,R2,#1 with R2=7FFF wraps
    load(3'd4, 16'h00FF);
    push(2'b11, 1'b1, 1'b0, 3'b100, 3'd6, 16'hFF00);
    issue(16'h9D3F, 1'b0, 3'd0, 16'h0);
    retire_wait();
    load(3'd2, 16'h7FFF);
    push(2'b01, 1'b1, 1'b0, 3'b100, 3'd2, 16'h8000);
    issue(16'h14A1, 1'b0, 3'd0, 16'h0);
    retire_wait();

    // Illegal opcodes: nothing written, nzp held at 100
    push(2'b00, 1'b0, 1'b1, 3'b100, 3'd6, 16'hFF00);
    issue(16'h0000, 1'b0, 3'd0, 16'h0);
    retire_wait();
    push(2'b00, 1'b0, 1'b1, 3'b100, 3'd2, 16'h8000);
    issue(16'hF025, 1'b0, 3'd0, 16'h0);
    retire_wait();

    // Back-to-back ADD R1,R1,#1 x3 from R1=0
    load(3'd1, 16'h0000);
    push(2'b01, 1'b1, 1'b0, 3'b001, 3'd1, 16'h0001);
    push(2'b01, 1'b1, 1'b0, 3'b001, 3'd1, 16'h0002);
    push(2'b01, 1'b1, 1'b0, 3'b001, 3'd1, 16'h0003);
    instr = 16'h1261; instrValid = 1'b1;
    count = 0;
    for (int n = 0; n < 30 && count < 3; n++) begin
      acc = instrReady;
      @(posedge clk); #1;
      if (acc) begin
        acc_cyc[count] = cyc;
        count++;
      end
    end
    instrValid = 1'b0;
    check("b2b_count", 16'(count), 16'd3);
    check("b2b_gap1", 16'(acc_cyc[1] - acc_cyc[0]), 16'd4);
    check("b2b_gap2", 16'(acc_cyc[2] - acc_cyc[1]), 16'd4);
    retire_wait();

    // loadEn during DECODE is ignored: R1 3 -> 4
    push(2'b01, 1'b1, 1'b0, 3'b001, 3'd1, 16'h0004);
    issue(16'h1261, 1'b0, 3'd0, 16'h0);
    loadEn = 1'b1; loadAddr = 3'd1; loadData = 16'h1234;
    @(posedge clk); #1;
    loadEn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // loadEn with accepted instrValid: DECODE sees R1=0010 -> 0011
    push(2'b01, 1'b1, 1'b0, 3'b001, 3'd1, 16'h0011);
    issue(16'h1261, 1'b1, 3'd1, 16'h0010);
    retire_wait();

    repeat (4) begin @(posedge clk); #1; end
    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
